mem_initiator: RTL



---
 rtl/mem_if_pkg.sv | 16 +
 rtl/mem_rsp_fifo.sv | 56 +++++
 rtl/mem_initiator.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and constants for the 64-bit internal memory port requester.
// The widths here fix the layout of a buffered read response.
package mem_if_pkg;

  localparam int CTW      = 16;
  localparam int SEQW     = 5;
  localparam int TagWidth = CTW + SEQW;

  localparam logic [7:0] BE_NONE = 8'hFF;

  typedef struct packed {
    logic [63:0]    data;
    logic [CTW-1:0] tag;
  } mem_rsp_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// First-word-fall-through response buffer. A push into a full FIFO is taken
// only when a pop frees a slot in the same cycle.
module mem_rsp_fifo
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  mem_rsp_t wdata,
  input  logic     pop,
  output mem_rsp_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  mem_rsp_t    mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit tells full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mem_initiator.sv
// Requester for the fixed-latency memory port: registered issue, credit-gated
// reads, in-order tag checking and a buffered response path to the client.
module mem_initiator
  import mem_if_pkg::*;
#(
  parameter int CTW   = mem_if_pkg::CTW,
  parameter int SEQW  = mem_if_pkg::SEQW,
  parameter int DEPTH = 4,
  localparam int TagWidth = CTW + SEQW
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic                REQ_WR,
  input  logic [15:0]         REQ_ADDR,
  input  logic [7:0]          REQ_BE,
  input  logic [63:0]         REQ_DATA,
  input  logic [CTW-1:0]      REQ_TAG,
  output logic                ACT,
  output logic                CMD,
  output logic [15:0]         ADDR,
  output logic [7:0]          BE,
  output logic [63:0]         DI,
  output logic [TagWidth-1:0] TI,
  input  logic                DRDY,
  input  logic [63:0]         DO,
  input  logic [TagWidth-1:0] TO,
  output logic                RSP_VALID,
  input  logic                RSP_READY,
  output logic [63:0]         RSP_DATA,
  output logic [CTW-1:0]      RSP_TAG,
  output logic                ERR
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                act_q, act_d;
  logic                cmd_q, cmd_d;
  logic [15:0]         addr_q, addr_d;
  logic [7:0]          be_q, be_d;
  logic [63:0]         di_q, di_d;
  logic [TagWidth-1:0] ti_q, ti_d;
  logic [SEQW-1:0]     issue_seq_q, issue_seq_d;
  logic [SEQW-1:0]     expect_seq_q, expect_seq_d;
  logic [CW-1:0]       credits_q, credits_d;
  logic                err_q, err_d;

  logic     accept, rd_accept, pop;
  logic     spurious, push_req, drop_full, seq_bad;
  logic     fifo_full, fifo_empty;
  mem_rsp_t push_rsp, head_rsp;

  // Credits count every read from issue until its response is popped, so a
  // return always finds room; RESETn gating keeps READY low during reset.
  assign REQ_READY = RESETn & (credits_q < CW'(DEPTH));
  assign accept    = REQ_VALID & REQ_READY;
  assign rd_accept = accept & ~REQ_WR;
  assign pop       = RSP_READY & ~fifo_empty;

  assign spurious  = DRDY & (credits_q == '0);
  assign push_req  = DRDY & ~spurious;
  assign drop_full = push_req & fifo_full & ~pop;
  assign seq_bad   = DRDY & (TO[SEQW-1:0] != expect_seq_q);

  assign push_rsp.data = DO;
  assign push_rsp.tag  = TO[TagWidth-1:SEQW];

  always_comb begin
    act_d        = 1'b0;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    be_d         = be_q;
    di_d         = di_q;
    ti_d         = ti_q;
    issue_seq_d  = issue_seq_q;
    expect_seq_d = expect_seq_q;
    credits_d    = credits_q;
    err_d        = err_q | seq_bad | spurious | drop_full;

    if (accept) begin
      act_d  = 1'b1;
      cmd_d  = ~REQ_WR;
      addr_d = REQ_ADDR;
      di_d   = REQ_DATA;
      be_d   = REQ_WR ? ~REQ_BE : BE_NONE;
      ti_d   = {REQ_TAG, issue_seq_q};
    end

    if (rd_accept) issue_seq_d  = issue_seq_q + 1'b1;
    if (DRDY)      expect_seq_d = expect_seq_q + 1'b1;

    case ({rd_accept, pop})
      2'b10:   credits_d = credits_q + 1'b1;
      2'b01:   credits_d = credits_q - 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      act_q        <= 1'b0;
      cmd_q        <= 1'b0;
      addr_q       <= '0;
      be_q         <= BE_NONE;
      di_q         <= '0;
      ti_q         <= '0;
      issue_seq_q  <= '0;
      expect_seq_q <= '0;
      credits_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      act_q        <= act_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      di_q         <= di_d;
      ti_q         <= ti_d;
      issue_seq_q  <= issue_seq_d;
      expect_seq_q <= expect_seq_d;
      credits_q    <= credits_d;
      err_q        <= err_d;
    end
  end

  mem_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESETn),
    .push  (push_req),
    .wdata (push_rsp),
    .pop   (RSP_READY),
    .rdata (head_rsp),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ACT       = act_q;
  assign CMD       = cmd_q;
  assign ADDR      = addr_q;
  assign BE        = be_q;
  assign DI        = di_q;
  assign TI        = ti_q;
  assign ERR       = err_q;
  assign RSP_VALID = ~fifo_empty;
  assign RSP_DATA  = head_rsp.data;
  assign RSP_TAG   = head_rsp.tag;

endmodule
